// File: rtl/carry_bypass_adder_pkg.sv
// rtl/carry_bypass_adder_pkg.sv - shared flag helpers for the carry-bypass adder
package carry_bypass_adder_pkg;

  typedef struct packed {
    logic cf;
    logic of_flag;
  } add_flags_t;

  // Signed overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic sign_overflow(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/carry_bypass_adder_cba_block.sv
// rtl/carry_bypass_adder_cba_block.sv - one ripple block with a block-propagate bypass mux
module cba_block #(
  parameter int BLOCK_SIZE = 1
) (
  input  logic [BLOCK_SIZE-1:0] a,
  input  logic [BLOCK_SIZE-1:0] b,
  input  logic                  cin,
  output logic [BLOCK_SIZE-1:0] s,
  output logic                  cout
);

  logic [BLOCK_SIZE-1:0] p;
  logic [BLOCK_SIZE-1:0] g;
  logic [BLOCK_SIZE:0]   c;
  logic                  blk_prop;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      s[i]   = p[i] ^ c[i];
    end
    blk_prop = &p;
    // When every bit propagates, the block carry-in skips the ripple path.
    cout     = blk_prop ? cin : c[BLOCK_SIZE];
  end

endmodule

// File: rtl/carry_bypass_adder.sv
// rtl/carry_bypass_adder.sv - carry-bypass adder with registered sum, carry and overflow flags
module carry_bypass_adder
  import carry_bypass_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BLOCK_SIZE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);

  localparam int NB = DATA_WIDTH / BLOCK_SIZE;

  if (DATA_WIDTH < 1 || BLOCK_SIZE < 1 || BLOCK_SIZE > DATA_WIDTH ||
      (DATA_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_params
    $error("carry_bypass_adder: illegal DATA_WIDTH/BLOCK_SIZE combination");
  end

  logic [DATA_WIDTH-1:0] sum_c;
  logic                  carry_out_c;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic cin_k;
    logic cout_k;

    if (k == 0) begin : g_first
      assign cin_k = Cin;
    end else begin : g_next
      assign cin_k = g_blk[k-1].cout_k;
    end

    cba_block #(.BLOCK_SIZE(BLOCK_SIZE)) u_blk (
      .a    (A[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .b    (B[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .cin  (cin_k),
      .s    (sum_c[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .cout (cout_k)
    );
  end

  assign carry_out_c = g_blk[NB-1].cout_k;

  logic [DATA_WIDTH-1:0] s_d, s_q;
  add_flags_t            flags_d, flags_q;
  logic                  c_into_msb;

  always_comb begin
    // The carry into the MSB is recovered from its sum bit: s = a ^ b ^ c.
    c_into_msb      = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1] ^ sum_c[DATA_WIDTH-1];
    s_d             = sum_c;
    flags_d.cf      = carry_out_c;
    flags_d.of_flag = sign_overflow(c_into_msb, carry_out_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      flags_q <= '0;
    end else begin
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  assign S  = s_q;
  assign CF = flags_q.cf;
  assign OF = flags_q.of_flag;

endmodule

// File: tb/tb_carry_bypass_adder.sv
// tb/tb_carry_bypass_adder.sv - directed and exhaustive checks of carry_bypass_adder
module tb_carry_bypass_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s1, s2, s4;
  logic       cf1, cf2, cf4;
  logic       of1, of2, of4;

  int checks;
  int failures;

  carry_bypass_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(1)) u_b1 (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .S(s1), .CF(cf1), .OF(of1));
  carry_bypass_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(2)) u_b2 (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .S(s2), .CF(cf2), .OF(of2));
  carry_bypass_adder #(.DATA_WIDTH(4), .BLOCK_SIZE(4)) u_b4 (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .S(s4), .CF(cf4), .OF(of4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={S,CF,OF}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected value packed as {S, CF, OF}; every block size must agree with it.
  task automatic chk3(input string tag, input logic [5:0] exp);
    chk({tag, "/bs1"}, {s1, cf1, of1}, exp);
    chk({tag, "/bs2"}, {s2, cf2, of2}, exp);
    chk({tag, "/bs4"}, {s4, cf4, of4}, exp);
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    a   = av;
    b   = bv;
    cin = cv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] sum;
    logic [5:0] exp;
    checks   = 0;
    failures = 0;

    rst = 1'b1;
    drive(4'b1010, 4'b0111, 1'b1);
    #2;
    chk3("reset_no_edge", 6'b0000_0_0);
    repeat (3) tick;
    chk3("reset_held", 6'b0000_0_0);
    rst = 1'b0;

    drive(4'b0001, 4'b0100, 1'b0);
    tick;
    chk3("add_0001_0100", 6'b0101_0_0);
    drive(4'b1101, 4'b1100, 1'b0);
    tick;
    chk3("add_1101_1100", 6'b1001_1_0);

    drive(4'b0101, 4'b0111, 1'b0);
    tick;
    chk3("ovf_0101_0111", 6'b1100_0_1);
    drive(4'b1000, 4'b1011, 1'b0);
    tick;
    chk3("ovf_1000_1011", 6'b0011_1_1);

    drive(4'b1111, 4'b0000, 1'b1);
    tick;
    chk3("bypass_1111_0000_c1", 6'b0000_1_0);

    // Back-to-back: outputs must hold until the next edge, then update.
    drive(4'b0011, 4'b0010, 1'b0);
    #6;
    chk3("b2b_hold_before_edge", 6'b0000_1_0);
    tick;
    chk3("b2b_first", 6'b0101_0_0);
    drive(4'b0111, 4'b0001, 1'b1);
    tick;
    chk3("b2b_second", 6'b1001_0_1);

    // Reset mid-stream: the in-flight 0110+0110 must never appear.
    drive(4'b0110, 4'b0110, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk3("midreset_async", 6'b0000_0_0);
    tick;
    chk3("midreset_edge", 6'b0000_0_0);
    rst = 1'b0;
    drive(4'b1110, 4'b0011, 1'b0);
    #6;
    chk3("midreset_before_first", 6'b0000_0_0);
    tick;
    chk3("midreset_first_result", 6'b0001_1_0);

    for (int i = 0; i < 512; i++) begin
      drive(i[3:0], i[7:4], i[8]);
      sum = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0, i[8]};
      exp = {sum[3:0], sum[4], (i[3] == i[7]) && (sum[3] != i[3])};
      tick;
      chk3("exhaustive", exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
